// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master byte transmitter.
//   spi_state_e : transmitter FSM states (GAP exists only in CS-gap builds)
//   SPI_BITS    : bits per frame
//   CLK_DIV_MIN : smallest legal SCK half-period in iclk cycles
//   CNT_W       : width of the half-period counter (CLK_DIV up to 255)
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      SCK_H = 3'd2,
      SCK_L = 3'd3,
      TRAIL = 3'd4,
      GAP   = 3'd5
   } spi_state_e;

   localparam int SPI_BITS    = 8;
   localparam int CLK_DIV_MIN = 3;
   localparam int CNT_W       = 8;

   // True when the bit counter points at the last bit of the frame.
   function automatic logic bit_last(input logic [2:0] bitcnt);
      return (bitcnt == 3'(SPI_BITS - 1));
   endfunction

endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: SCK half-period counter.
//   iclk  in  system clock
//   rstn  in  asynchronous active-low reset
//   clr   in  restart the half-period (asserted on every FSM state change)
//   tick  out last cycle of the current half-period (cnt == CLK_DIV-1)
module spi_half_tick
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic iclk,
   input  logic rstn,
   input  logic clr,
   output logic tick
);

   logic [CNT_W-1:0] cnt_r;

   assign tick = (cnt_r == CNT_W'(CLK_DIV - 1));

   // Half-period counter: wraps on tick, restarts on clear.
   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr || tick) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_m2s.sv
// spi_m2s: SPI master byte transmitter, mode 0, MSB first.
//   iclk  in   system clock
//   rstn  in   asynchronous active-low reset
//   start in   transfer request (ignored while busy)
//   din   in   byte to send, captured when start is accepted
//   busy  out  transfer in progress
//   done  out  one-cycle completion pulse
//   CS    out  chip select, active low
//   SCK   out  serial clock, idle low
//   MOSI  out  serial data, changes on SCK falling edges or CS assertion
// Build option: SPI_M2S_CS_GAP_EN adds a GAP state of CLK_DIV cycles after
// each frame, holding CS high and busy set; done pulses on GAP entry.
module spi_m2s
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       iclk,
   input  logic       rstn,
   input  logic       start,
   input  logic [7:0] din,
   output logic       busy,
   output logic       done,
   output logic       CS,
   output logic       SCK,
   output logic       MOSI
);

   spi_state_e  state_r, state_nxt_s;
   // din[7] goes straight to MOSI, so only the remaining seven bits are held.
   logic [6:0]  shreg_r, shreg_nxt_s;
   logic [2:0]  bitcnt_r, bitcnt_nxt_s;
   logic        busy_r, done_r, cs_r, sck_r, mosi_r;
   logic        busy_nxt_s, done_nxt_s, cs_nxt_s, sck_nxt_s, mosi_nxt_s;
   logic        tick_s, clr_s;

   // Counter is held at zero in IDLE so LEAD always starts a full half-period.
   assign clr_s = (state_nxt_s != state_r) || (state_r == IDLE);

   spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
      .iclk (iclk),
      .rstn (rstn),
      .clr  (clr_s),
      .tick (tick_s)
   );

   // Next-state and next-output logic for the transmit FSM.
   always_comb begin
      state_nxt_s  = state_r;
      shreg_nxt_s  = shreg_r;
      bitcnt_nxt_s = bitcnt_r;
      cs_nxt_s     = cs_r;
      sck_nxt_s    = sck_r;
      mosi_nxt_s   = mosi_r;
      done_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               shreg_nxt_s  = din[6:0];
               bitcnt_nxt_s = 3'd0;
               cs_nxt_s     = 1'b0;
               mosi_nxt_s   = din[7];
               state_nxt_s  = LEAD;
            end else begin
               cs_nxt_s  = 1'b1;
               sck_nxt_s = 1'b0;
            end
         end
         LEAD: begin
            if (tick_s) begin
               sck_nxt_s   = 1'b1;
               state_nxt_s = SCK_H;
            end else begin
               state_nxt_s = LEAD;
            end
         end
         SCK_H: begin
            if (tick_s) begin
               sck_nxt_s = 1'b0;
               if (bit_last(bitcnt_r)) begin
                  state_nxt_s = TRAIL;
               end else begin
                  bitcnt_nxt_s = bitcnt_r + 3'd1;
                  mosi_nxt_s   = shreg_r[6];
                  shreg_nxt_s  = {shreg_r[5:0], 1'b0};
                  state_nxt_s  = SCK_L;
               end
            end else begin
               state_nxt_s = SCK_H;
            end
         end
         SCK_L: begin
            if (tick_s) begin
               sck_nxt_s   = 1'b1;
               state_nxt_s = SCK_H;
            end else begin
               state_nxt_s = SCK_L;
            end
         end
         TRAIL: begin
            if (tick_s) begin
               cs_nxt_s    = 1'b1;
               mosi_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
`ifdef SPI_M2S_CS_GAP_EN
               state_nxt_s = GAP;
`else
               state_nxt_s = IDLE;
`endif
            end else begin
               state_nxt_s = TRAIL;
            end
         end
`ifdef SPI_M2S_CS_GAP_EN
         // Start is honoured on the last GAP cycle so CS stays high for
         // exactly CLK_DIV cycles between back-to-back frames.
         GAP: begin
            if (tick_s && start) begin
               shreg_nxt_s  = din[6:0];
               bitcnt_nxt_s = 3'd0;
               cs_nxt_s     = 1'b0;
               mosi_nxt_s   = din[7];
               state_nxt_s  = LEAD;
            end else if (tick_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = GAP;
            end
         end
`endif
         default: begin
            state_nxt_s = IDLE;
            cs_nxt_s    = 1'b1;
            sck_nxt_s   = 1'b0;
            mosi_nxt_s  = 1'b0;
         end
      endcase
      busy_nxt_s = (state_nxt_s != IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= IDLE;
         shreg_r  <= 7'd0;
         bitcnt_r <= 3'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         cs_r     <= 1'b1;
         sck_r    <= 1'b0;
         mosi_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         shreg_r  <= shreg_nxt_s;
         bitcnt_r <= bitcnt_nxt_s;
         busy_r   <= busy_nxt_s;
         done_r   <= done_nxt_s;
         cs_r     <= cs_nxt_s;
         sck_r    <= sck_nxt_s;
         mosi_r   <= mosi_nxt_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign CS   = cs_r;
   assign SCK  = sck_r;
   assign MOSI = mosi_r;

endmodule

// File: tb/tb_spi_m2s.sv
// tb_spi_m2s: directed bench for spi_m2s with a behavioural mode-0 receiver.
module tb_spi_m2s;

`ifdef SPI_M2S_CS_GAP_EN
   localparam int CD        = 5;
   localparam int GAP_EXP   = 5;   // CS-high cycles between held-start frames
   localparam logic BUSY_AT_DONE = 1'b1;
`else
   localparam int CD        = 4;
   localparam int GAP_EXP   = 1;
   localparam logic BUSY_AT_DONE = 1'b0;
`endif
   // Start cycle to done cycle: 17 half-periods plus one; 69 for CD=4.
   localparam int LAT = 17 * CD + 1;

   logic       iclk  = 1'b0;
   logic       rstn  = 1'b0;
   logic       start = 1'b0;
   logic [7:0] din   = 8'h00;
   logic       busy, done, cs, sck, mosi;

   int checks   = 0;
   int failures = 0;

   always #5 iclk = ~iclk;

   spi_m2s #(.CLK_DIV(CD)) dut (
      .iclk  (iclk),
      .rstn  (rstn),
      .start (start),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .CS    (cs),
      .SCK   (sck),
      .MOSI  (mosi)
   );

   // Receiver model: shift MOSI on SCK rising edges while CS is low.
   logic       sck_q = 1'b0;
   logic       cs_q  = 1'b1;
   logic [7:0] sh    = 8'h00;
   int         edges    = 0;
   int         hi_run   = 0;
   int         last_gap = 0;
   int         cs_falls = 0;
   logic [7:0] rx_q[$];
   int         rx_edges[$];

   always @(posedge iclk) begin
      if (!cs && sck && !sck_q) begin
         sh    <= {sh[6:0], mosi};
         edges <= edges + 1;
      end
      if (cs_q && !cs) begin
         edges    <= 0;
         cs_falls <= cs_falls + 1;
         last_gap <= hi_run;
      end
      if (!cs_q && cs) begin
         rx_q.push_back(sh);
         rx_edges.push_back(edges);
      end
      hi_run <= cs ? hi_run + 1 : 0;
      sck_q  <= sck;
      cs_q   <= cs;
   end

   // Request a byte; returns in the cycle after acceptance and checks it.
   task automatic start_byte(input logic [7:0] b);
      @(negedge iclk);
      start = 1'b1;
      din   = b;
      @(negedge iclk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || cs !== 1'b0 || mosi !== b[7]) begin
         failures++;
         $display("FAIL accept_outputs byte=%02h: busy=%b CS=%b MOSI=%b, required busy=1 CS=0 MOSI=%b",
                  b, busy, cs, mosi, b[7]);
      end
   endtask

   // Wait (bounded) for done; k = negedges waited.
   task automatic wait_done(output int k);
      logic seen;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 400) begin
         @(negedge iclk);
         k++;
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL done_timeout: no done after %0d cycles, required within 400", k);
      end
   endtask

   // Full transfer with latency, pulse-width and received-byte checks.
   task automatic send_and_check(input logic [7:0] b);
      int k;
      start_byte(b);
      wait_done(k);
      checks++;
      if (k + 1 != LAT) begin
         failures++;
         $display("FAIL done_latency byte=%02h: got %0d, required %0d", b, k + 1, LAT);
      end
      checks++;
      if (cs !== 1'b1 || busy !== BUSY_AT_DONE) begin
         failures++;
         $display("FAIL done_cycle byte=%02h: CS=%b busy=%b, required CS=1 busy=%b",
                  b, cs, busy, BUSY_AT_DONE);
      end
      @(negedge iclk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_width byte=%02h: done=%b one cycle later, required 0", b, done);
      end
      repeat (CD + 2) @(negedge iclk);
      checks++;
      if (rx_q.size() != 1) begin
         failures++;
         $display("FAIL rx_count byte=%02h: got %0d frames, required 1", b, rx_q.size());
      end else begin
         checks++;
         if (rx_q[0] !== b || rx_edges[0] != 8) begin
            failures++;
            $display("FAIL rx_byte: got %02h with %0d edges, required %02h with 8 edges",
                     rx_q[0], rx_edges[0], b);
         end
      end
      rx_q.delete();
      rx_edges.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge iclk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cs !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b CS=%b SCK=%b MOSI=%b, required 0 0 1 0 0",
                  busy, done, cs, sck, mosi);
      end
      rstn = 1'b1;
      repeat (2) @(negedge iclk);
      checks++;
      if (busy !== 1'b0 || cs !== 1'b1 || sck !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: busy=%b CS=%b SCK=%b, required 0 1 0", busy, cs, sck);
      end
      rx_q.delete();
      rx_edges.delete();
   endtask

   task automatic test_loopback();
      send_and_check(8'hA5);
   endtask

   task automatic test_patterns();
      logic [7:0] pats [4];
      pats = '{8'h00, 8'hFF, 8'h80, 8'h01};
      for (int i = 0; i < 4; i++) send_and_check(pats[i]);
   endtask

   task automatic test_ignore_start();
      int k;
      int falls0;
      falls0 = cs_falls;
      start_byte(8'h5A);
      repeat (8) @(negedge iclk);
      start = 1'b1;
      din   = 8'h3C;
      @(negedge iclk);
      start = 1'b0;
      wait_done(k);
      checks++;
      if (k + 10 != LAT) begin
         failures++;
         $display("FAIL ignore_latency: got %0d, required %0d", k + 10, LAT);
      end
      repeat (3 * CD) @(negedge iclk);
      checks++;
      if (cs_falls - falls0 != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_frames: %0d CS assertions busy=%b, required 1 and busy=0",
                  cs_falls - falls0, busy);
      end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
         failures++;
         $display("FAIL ignore_rx: got %0d frames first=%02h, required 1 frame 5a",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
      rx_q.delete();
      rx_edges.delete();
   endtask

   task automatic test_back_to_back();
      int k;
      int w;
      int falls0;
      falls0 = cs_falls;
      @(negedge iclk);
      start = 1'b1;
      din   = 8'h12;
      wait_done(k);
      checks++;
      if (k != LAT) begin
         failures++;
         $display("FAIL b2b_latency: got %0d, required %0d", k, LAT);
      end
      din = 8'h34;
      w   = 0;
      while (cs !== 1'b0 && w < 3 * CD) begin
         @(negedge iclk);
         w++;
      end
      start = 1'b0;
      checks++;
      if (cs !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second_frame: CS=%b, required 0 within %0d cycles", cs, 3 * CD);
      end
      wait_done(k);
      repeat (CD + 2) @(negedge iclk);
      checks++;
      if (last_gap != GAP_EXP) begin
         failures++;
         $display("FAIL b2b_cs_gap: CS high %0d cycles, required %0d", last_gap, GAP_EXP);
      end
      checks++;
      if (rx_q.size() != 2 || cs_falls - falls0 != 2) begin
         failures++;
         $display("FAIL b2b_frames: rx=%0d falls=%0d, required 2 and 2",
                  rx_q.size(), cs_falls - falls0);
      end else begin
         checks++;
         if (rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin
            failures++;
            $display("FAIL b2b_bytes: got %02h %02h, required 12 34", rx_q[0], rx_q[1]);
         end
      end
      rx_q.delete();
      rx_edges.delete();
   endtask

   task automatic test_reset_mid();
      start_byte(8'h77);
      repeat (29) @(negedge iclk);
      checks++;
      if (busy !== 1'b1 || cs !== 1'b0) begin
         failures++;
         $display("FAIL mid_transfer: busy=%b CS=%b, required 1 0", busy, cs);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (cs !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: CS=%b SCK=%b MOSI=%b busy=%b done=%b, required 1 0 0 0 0",
                  cs, sck, mosi, busy, done);
      end
      @(negedge iclk);
      rstn = 1'b1;
      repeat (2) @(negedge iclk);
      rx_q.delete();
      rx_edges.delete();
      send_and_check(8'hC3);
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_patterns();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
